// File: rtl/rshift_serial_if.sv
// Handshake and operand bundle for the multi-cycle right shifter.
// RSHIFT_ARITH_EN adds the arith select signal.
interface rshift_serial_if #(
  parameter int ancho = 4
);
  logic             start;
  logic [ancho-1:0] a;
  logic [ancho-1:0] b;
  logic             aluflagin;
`ifdef RSHIFT_ARITH_EN
  logic             arith;
`endif
  logic             busy;
  logic             done;
  logic [ancho-1:0] aluresult;
  logic             aluflags;

`ifdef RSHIFT_ARITH_EN
  modport master (
    output start, a, b, aluflagin, arith,
    input  busy, done, aluresult, aluflags
  );

  modport slave (
    input  start, a, b, aluflagin, arith,
    output busy, done, aluresult, aluflags
  );
`else
  modport master (
    output start, a, b, aluflagin,
    input  busy, done, aluresult, aluflags
  );

  modport slave (
    input  start, a, b, aluflagin,
    output busy, done, aluresult, aluflags
  );
`endif
endinterface

// File: rtl/rshift_serial.sv
// Multi-cycle logical right shifter: one bit position per clock, start/busy/done handshake.
// Define RSHIFT_ARITH_EN to add an arithmetic (sign-fill) mode selected by bus.arith.
module rshift_serial #(
  parameter int ancho = 4
) (
  input logic            clk,
  input logic            rst_n,
  rshift_serial_if.slave bus
);

  localparam int               cnt_w     = $clog2(ancho + 1);
  localparam logic [ancho-1:0] max_shift = ancho'(ancho);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FIN
  } state_t;

  state_t           state, state_nxt;
  logic [ancho-1:0] sreg, sreg_nxt;
  logic [cnt_w-1:0] cnt, cnt_nxt;
  logic             fill, fill_nxt;
  logic             flag, flag_nxt;
  logic [ancho-1:0] result_q;
  logic             flags_q;
  logic [cnt_w-1:0] cnt_load;
  logic             start_fill;

  // Any shift of ancho or more pushes every operand bit out, so clamp the count.
  always_comb begin
    if (bus.b >= max_shift) cnt_load = cnt_w'(ancho);
    else                    cnt_load = cnt_w'(bus.b);
  end

`ifdef RSHIFT_ARITH_EN
  assign start_fill = bus.arith ? bus.a[ancho-1] : bus.aluflagin;
`else
  assign start_fill = bus.aluflagin;
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    fill_nxt  = fill;
    flag_nxt  = flag;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          sreg_nxt  = bus.a;
          fill_nxt  = start_fill;
          flag_nxt  = 1'b0;
          cnt_nxt   = cnt_load;
          state_nxt = (cnt_load != '0) ? SHIFT : FIN;
        end
      end
      SHIFT: begin
        sreg_nxt = {fill, sreg[ancho-1:1]};
        flag_nxt = sreg[0];
        cnt_nxt  = cnt - cnt_w'(1);
        if (cnt == cnt_w'(1)) state_nxt = FIN;
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the datapath is a handful of flops, not a memory, so all of it is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg     <= '0;
      cnt      <= '0;
      fill     <= 1'b0;
      flag     <= 1'b0;
      result_q <= '0;
      flags_q  <= 1'b0;
    end else begin
      sreg <= sreg_nxt;
      cnt  <= cnt_nxt;
      fill <= fill_nxt;
      flag <= flag_nxt;
      // Publish on the edge entering FIN so the result is valid alongside done.
      if (state_nxt == FIN) begin
        result_q <= sreg_nxt;
        flags_q  <= flag_nxt;
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == FIN);
  assign bus.aluresult = result_q;
  assign bus.aluflags  = flags_q;

endmodule
